k2_run_controller: RTL and testbench
====================================

Name: k2_run_controller

Overview:
Sequences one K2 processor-with-memory core through repeated program runs. It owns the core's reset and selects the active program ROM, one of NUM_PROGS, through an external instruction mux. It detects program completion as a self-loop halt, or a cycle-budget timeout, and latches the core's Ro result. It sits between board-level start/select controls and the K2 core plus its program ROM mux.

Parameters:
NUM_PROGS, 4, number of selectable program ROMs; select width SEL_W = clog2(NUM_PROGS)
ADDR_W, 4, width of the core's ProgramAddress
BITS, 8, width of the core's Ro result
CYC_W, 16, width of the cycle counter and budget
HALT_REPEAT, 4, consecutive cycles with an unchanged ProgramAddress that count as a halt
RST_HOLD, 2, cycles core_rst_n is held low before each run

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle run request
abort  input  1  one-cycle abort request
prog_sel  input  SEL_W  program to run; sampled when start is accepted
max_cycles  input  CYC_W  cycle budget; sampled when start is accepted; 0 means no limit
program_address  input  ADDR_W  ProgramAddress from the core
ro  input  BITS  Ro from the core
core_rst_n  output  1  active-low reset to the core
prog_idx  output  SEL_W  select for the instruction-ROM mux
busy  output  1  high in RESET_CORE and RUN
done  output  1  one-cycle pulse when a run ends (halt, timeout or abort)
timed_out  output  1  sticky; set if the last run hit the budget
aborted  output  1  sticky; set if the last run was aborted
result  output  BITS  Ro captured at halt
cycle_count  output  CYC_W  RUN cycles of the last or current run

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, core_rst_n=0, prog_idx=0, busy=0, done=0, timed_out=0, aborted=0, result=0, cycle_count=0. Reset mid-run drops straight to IDLE with the core held in reset.
- States:
  - IDLE: core_rst_n=0. If start=1: latch prog_sel into prog_idx and max_cycles into the budget, clear timed_out, aborted and cycle_count, then go to RESET_CORE.
  - RESET_CORE: core_rst_n=0 for exactly RST_HOLD cycles, so prog_idx is stable before the core leaves reset. Then go to RUN.
  - RUN: core_rst_n=1. cycle_count increments every cycle and saturates at all-ones.
    - Halt: program_address equals its previous-cycle value for HALT_REPEAT consecutive cycles. On halt, result<=ro and go to DONE.
    - Timeout: budget != 0 and cycle_count+1 == budget with no halt. Set timed_out, leave result unchanged, go to DONE.
    - If halt and timeout fire in the same cycle, halt wins and timed_out stays 0.
  - DONE: done=1 for this single cycle; core_rst_n=0. Next state is IDLE.
- Core reset between runs: core_rst_n is 0 in every state except RUN, so the core is re-reset before each run.
- Start acceptance: start is honoured only in IDLE. In RESET_CORE, RUN and DONE it is ignored and is not queued.
- Abort: abort=1 in RESET_CORE or RUN sets aborted and goes to DONE next cycle; result is unchanged. abort in IDLE or DONE is ignored. Abort beats halt and timeout in the same cycle.
- Start and abort together in IDLE: start wins, because abort is ignored in IDLE.
- Latency: from start accepted to the first RUN cycle is RST_HOLD+1 clocks. From the halt-detect cycle to the done pulse is 1 clock.
- Halt detector: it restarts counting on the first RUN cycle, so a stale address from reset cannot trigger a halt. The repeat count compares against HALT_REPEAT-1 matches after a reference sample.
- prog_idx holds its value after the run, until the next accepted start.
- prog_sel >= NUM_PROGS is clamped to NUM_PROGS-1.

Decomposition:
- Shared package k2_ctrl_pkg:
  - state enum (IDLE, RESET_CORE, RUN, DONE)
  - default parameter constants
  - the clamp function for prog_sel
- One sub-module, k2_halt_detector:
  - inputs: clk, rst, clear, enable, program_address
  - output: halted
  - internals: stored previous address plus a repeat counter of width clog2(HALT_REPEAT)+1

Test Plan:
- rst pulse mid-RUN -> on the same edge: core_rst_n=0, busy=0, state IDLE; prog_idx=0; result keeps 0.
- prog_sel=2, max_cycles=0, start; model addr 0..5 then held at 5, ro=8'd13 -> busy for 2 reset cycles; done pulses 1 clock after the 4th cycle at addr 5; result=13; timed_out=0; prog_idx=2.
- max_cycles=10, addr never repeats -> done after RUN cycle 10; timed_out=1; result unchanged; cycle_count=10.
- abort in RUN cycle 3 -> done next clock; aborted=1; core_rst_n=0; a second start pulse during RUN before the abort causes no extra run.
- Halt and timeout coincide (budget equals halt cycle) -> timed_out=0, result captured.
- prog_sel=7 with NUM_PROGS=4 -> prog_idx=3; a back-to-back start in the clock after done is accepted, and core_rst_n is low for 2 cycles again.

Source files
------------

// File: rtl/k2_ctrl_pkg.sv
// Shared types, default parameters and helpers for the K2 run controller.
package k2_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RESET_CORE = 2'd1,
      RUN        = 2'd2,
      DONE       = 2'd3
   } k2_state_e;

   localparam int unsigned K2_NUM_PROGS   = 32'd4;
   localparam int unsigned K2_ADDR_W      = 32'd4;
   localparam int unsigned K2_BITS        = 32'd8;
   localparam int unsigned K2_CYC_W       = 32'd16;
   localparam int unsigned K2_HALT_REPEAT = 32'd4;
   localparam int unsigned K2_RST_HOLD    = 32'd2;

   // Out-of-range program selects map onto the last ROM.
   function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned num_progs);
      int unsigned r;
      if (sel >= num_progs) begin
         r = num_progs - 32'd1;
      end else begin
         r = sel;
      end
      return r;
   endfunction

endpackage

// File: rtl/k2_halt_detector.sv
// Flags a self-loop halt: the core's ProgramAddress held for HALT_REPEAT
// consecutive enabled cycles (one reference sample plus HALT_REPEAT-1 matches).
module k2_halt_detector
   import k2_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = K2_ADDR_W,
   parameter int unsigned HALT_REPEAT = K2_HALT_REPEAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              enable,
   input  logic [ADDR_W-1:0] program_address,
   output logic              halted
);

   localparam int unsigned       CNT_W    = $clog2(HALT_REPEAT) + 32'd1;
   localparam logic [CNT_W-1:0]  CNT_HALT = CNT_W'(HALT_REPEAT - 32'd2);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);

   logic [ADDR_W-1:0] prev_q, prev_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ref_q, ref_d;
   logic              match_s;

   // Match tracking; ref_q stays low until the first enabled sample so stale addresses never count.
   always_comb begin
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      ref_d   = ref_q;
      match_s = ref_q && (program_address == prev_q);
      halted  = enable && match_s && (cnt_q == CNT_HALT);
      if (clear) begin
         prev_d = {ADDR_W{1'b0}};
         cnt_d  = {CNT_W{1'b0}};
         ref_d  = 1'b0;
      end else if (enable) begin
         if (match_s) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
         end else begin
            prev_d = program_address;
            cnt_d  = {CNT_W{1'b0}};
            ref_d  = 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Detector state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= {ADDR_W{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
         ref_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         ref_q  <= ref_d;
      end
   end

endmodule

// File: rtl/k2_run_controller.sv
// Sequences one K2 core through program runs: core reset, ROM select,
// halt/timeout/abort detection and result capture.
module k2_run_controller
   import k2_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PROGS   = K2_NUM_PROGS,
   parameter int unsigned ADDR_W      = K2_ADDR_W,
   parameter int unsigned BITS        = K2_BITS,
   parameter int unsigned CYC_W       = K2_CYC_W,
   parameter int unsigned HALT_REPEAT = K2_HALT_REPEAT,
   parameter int unsigned RST_HOLD    = K2_RST_HOLD,
   localparam int unsigned SEL_W      = (NUM_PROGS > 32'd1) ? $clog2(NUM_PROGS) : 32'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [SEL_W-1:0]  prog_sel,
   input  logic [CYC_W-1:0]  max_cycles,
   input  logic [ADDR_W-1:0] program_address,
   input  logic [BITS-1:0]   ro,
   output logic              core_rst_n,
   output logic [SEL_W-1:0]  prog_idx,
   output logic              busy,
   output logic              done,
   output logic              timed_out,
   output logic              aborted,
   output logic [BITS-1:0]   result,
   output logic [CYC_W-1:0]  cycle_count
);

   localparam int unsigned      HOLD_W    = $clog2(RST_HOLD) + 32'd1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
   localparam logic [CYC_W-1:0]  CYC_MAX   = {CYC_W{1'b1}};
   localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(32'd1);

   k2_state_e         state_q, state_d;
   logic [SEL_W-1:0]  prog_idx_q, prog_idx_d;
   logic [CYC_W-1:0]  budget_q, budget_d;
   logic [CYC_W-1:0]  cycle_q, cycle_d;
   logic [BITS-1:0]   result_q, result_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timed_out_q, timed_out_d;
   logic              aborted_q, aborted_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              core_rst_n_q, core_rst_n_d;
   logic              halted_s;
   logic              timeout_s;

   k2_halt_detector #(
      .ADDR_W      (ADDR_W),
      .HALT_REPEAT (HALT_REPEAT)
   ) u_halt (
      .clk             (clk),
      .rst             (rst),
      .clear           (state_q != RUN),
      .enable          (state_q == RUN),
      .program_address (program_address),
      .halted          (halted_s)
   );

   // Widened compare so a saturated counter can never alias a budget.
   assign timeout_s = (budget_q != {CYC_W{1'b0}}) &&
                      (({1'b0, cycle_q} + {{CYC_W{1'b0}}, 1'b1}) == {1'b0, budget_q});

   // Next-state and output decode; abort outranks halt, halt outranks timeout.
   always_comb begin
      state_d     = state_q;
      prog_idx_d  = prog_idx_q;
      budget_d    = budget_q;
      cycle_d     = cycle_q;
      result_d    = result_q;
      hold_d      = hold_q;
      timed_out_d = timed_out_q;
      aborted_d   = aborted_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               prog_idx_d  = SEL_W'(clamp_sel(32'(prog_sel), NUM_PROGS));
               budget_d    = max_cycles;
               cycle_d     = {CYC_W{1'b0}};
               hold_d      = {HOLD_W{1'b0}};
               timed_out_d = 1'b0;
               aborted_d   = 1'b0;
               state_d     = RESET_CORE;
            end else begin
               state_d = IDLE;
            end
         end
         RESET_CORE: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (hold_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         RUN: begin
            cycle_d = (cycle_q == CYC_MAX) ? cycle_q : cycle_q + CYC_ONE;
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (halted_s) begin
               result_d = ro;
               state_d  = DONE;
            end else if (timeout_s) begin
               timed_out_d = 1'b1;
               state_d     = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d       = (state_d == RESET_CORE) || (state_d == RUN);
      done_d       = (state_d == DONE);
      core_rst_n_d = (state_d == RUN);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prog_idx_q   <= {SEL_W{1'b0}};
         budget_q     <= {CYC_W{1'b0}};
         cycle_q      <= {CYC_W{1'b0}};
         result_q     <= {BITS{1'b0}};
         hold_q       <= {HOLD_W{1'b0}};
         timed_out_q  <= 1'b0;
         aborted_q    <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prog_idx_q   <= prog_idx_d;
         budget_q     <= budget_d;
         cycle_q      <= cycle_d;
         result_q     <= result_d;
         hold_q       <= hold_d;
         timed_out_q  <= timed_out_d;
         aborted_q    <= aborted_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   assign core_rst_n  = core_rst_n_q;
   assign prog_idx    = prog_idx_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timed_out   = timed_out_q;
   assign aborted     = aborted_q;
   assign result      = result_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_k2_run_controller.sv
// Randomized self-checking bench for k2_run_controller against a trace-level run model.
module tb_k2_run_controller;

   localparam int NUM_PROGS   = 4;
   localparam int ADDR_W      = 4;
   localparam int BITS        = 8;
   localparam int CYC_W       = 16;
   localparam int HALT_REPEAT = 4;
   localparam int RST_HOLD    = 2;
   localparam int SEL_W       = 2;
   localparam int TR_N        = 64;

   logic              clk = 1'b0;
   logic              rst, start, abort;
   logic [SEL_W-1:0]  prog_sel;
   logic [CYC_W-1:0]  max_cycles;
   logic [ADDR_W-1:0] program_address;
   logic [BITS-1:0]   ro;
   logic              core_rst_n, busy, done, timed_out, aborted;
   logic [SEL_W-1:0]  prog_idx;
   logic [BITS-1:0]   result;
   logic [CYC_W-1:0]  cycle_count;

   int n_tests = 0;
   int n_fail  = 0;
   int tr_addr [TR_N];
   int tr_ro   [TR_N];
   int exp_result = 0;
   int exp_idx    = 0;
   int exp_cnt    = 0;
   int exp_to     = 0;
   int exp_ab     = 0;

   k2_run_controller #(
      .NUM_PROGS(NUM_PROGS), .ADDR_W(ADDR_W), .BITS(BITS), .CYC_W(CYC_W),
      .HALT_REPEAT(HALT_REPEAT), .RST_HOLD(RST_HOLD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_sel(prog_sel),
      .max_cycles(max_cycles), .program_address(program_address), .ro(ro),
      .core_rst_n(core_rst_n), .prog_idx(prog_idx), .busy(busy), .done(done),
      .timed_out(timed_out), .aborted(aborted), .result(result), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string ph);
      check_eq({ph, "_busy"},     int'(busy), 0);
      check_eq({ph, "_done"},     int'(done), 0);
      check_eq({ph, "_core_rst"}, int'(core_rst_n), 0);
      check_eq({ph, "_prog_idx"}, int'(prog_idx), exp_idx);
      check_eq({ph, "_result"},   int'(result), exp_result);
      check_eq({ph, "_to"},       int'(timed_out), exp_to);
      check_eq({ph, "_ab"},       int'(aborted), exp_ab);
      check_eq({ph, "_cnt"},      int'(cycle_count), exp_cnt);
   endtask

   task automatic gen_trace();
      int p;
      p = $urandom_range(4, 40);
      for (int i = 0; i < TR_N; i++) begin
         if (i >= p) tr_addr[i] = tr_addr[p-1];
         else if (i > 0 && $urandom_range(0, 3) == 0) tr_addr[i] = tr_addr[i-1];
         else tr_addr[i] = $urandom_range(0, 15);
         tr_ro[i] = $urandom_range(0, 255);
      end
   endtask

   // One complete run starting in an IDLE cycle; ends in the IDLE cycle after done.
   task automatic do_run(input int sel, input int budget, input int abort_k, input bit noise);
      int  halt_k, to_k, end_k, seen;
      bit  same;
      halt_k = -1;
      for (int k = HALT_REPEAT - 1; k < TR_N && halt_k < 0; k++) begin
         same = 1'b1;
         for (int j = 1; j < HALT_REPEAT; j++) if (tr_addr[k-j] != tr_addr[k]) same = 1'b0;
         if (same) halt_k = k;
      end
      to_k  = (budget != 0) ? budget - 1 : -1;
      end_k = TR_N - 1;
      if (halt_k >= 0 && halt_k < end_k) end_k = halt_k;
      if (to_k >= 0 && to_k < end_k) end_k = to_k;
      if (abort_k >= 0 && abort_k <= end_k) end_k = abort_k;

      prog_sel        = SEL_W'(sel);
      max_cycles      = CYC_W'(budget);
      program_address = ADDR_W'(tr_addr[0]);
      ro              = BITS'($urandom);
      start           = 1'b1;
      abort           = noise;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      seen    = sel % (1 << SEL_W);
      exp_idx = (seen > NUM_PROGS - 1) ? NUM_PROGS - 1 : seen;
      exp_to  = 0;
      exp_ab  = 0;
      exp_cnt = 0;
      for (int r = 0; r < RST_HOLD; r++) begin
         check_eq("rc_core_rst", int'(core_rst_n), 0);
         check_eq("rc_busy",     int'(busy), 1);
         check_eq("rc_done",     int'(done), 0);
         check_eq("rc_prog_idx", int'(prog_idx), exp_idx);
         check_eq("rc_flags",    int'({timed_out, aborted}), 0);
         check_eq("rc_cnt",      int'(cycle_count), 0);
         start = noise;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int k = 0; k <= end_k; k++) begin
         program_address = ADDR_W'(tr_addr[k]);
         ro              = BITS'(tr_ro[k]);
         abort           = (k == abort_k);
         start           = noise && (k == 1);
         check_eq("run_core_rst", int'(core_rst_n), 1);
         check_eq("run_busy",     int'(busy), 1);
         check_eq("run_done",     int'(done), 0);
         check_eq("run_cnt",      int'(cycle_count), k);
         @(posedge clk); #1;
      end
      abort = 1'b0;
      start = 1'b0;
      exp_cnt = end_k + 1;
      if (abort_k == end_k) exp_ab = 1;
      else if (halt_k == end_k) exp_result = tr_ro[end_k];
      else if (to_k == end_k) exp_to = 1;
      check_eq("done_pulse",    int'(done), 1);
      check_eq("done_busy",     int'(busy), 0);
      check_eq("done_core_rst", int'(core_rst_n), 0);
      check_eq("done_result",   int'(result), exp_result);
      check_eq("done_to",       int'(timed_out), exp_to);
      check_eq("done_ab",       int'(aborted), exp_ab);
      check_eq("done_cnt",      int'(cycle_count), exp_cnt);
      check_eq("done_prog_idx", int'(prog_idx), exp_idx);
      start = noise;
      abort = noise;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check_idle("after_done");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; prog_sel = '0; max_cycles = '0;
      program_address = '0; ro = '0;
      #1;
      check_idle("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("post_reset");

      // Halt on a held address.
      for (int i = 0; i < TR_N; i++) begin tr_addr[i] = (i < 6) ? i : 5; tr_ro[i] = 13; end
      do_run(2, 0, -1, 1'b0);
      // Timeout with an ever-changing address.
      for (int i = 0; i < TR_N; i++) begin tr_addr[i] = i % 16; tr_ro[i] = 200 + (i % 50); end
      do_run(1, 10, -1, 1'b0);
      // Abort with a stray start during the run.
      do_run(0, 0, 3, 1'b1);
      // Halt and timeout on the same cycle.
      for (int i = 0; i < TR_N; i++) begin tr_addr[i] = (i < 6) ? i : 5; tr_ro[i] = 100 + i; end
      do_run(3, 9, -1, 1'b0);
      // Oversized select, then a back-to-back start.
      do_run(7, 0, -1, 1'b1);
      gen_trace();
      do_run(1, 0, -1, 1'b0);

      repeat (30) begin
         gen_trace();
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check_idle("gap");
         end
         do_run($urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 50),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1,
                1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a run.
      prog_sel = 2'd2; max_cycles = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < RST_HOLD + 3; i++) begin
         program_address = ADDR_W'(i);
         @(posedge clk); #1;
      end
      check_eq("pre_rst_core_rst", int'(core_rst_n), 1);
      #2 rst = 1'b1;
      #1;
      exp_idx = 0; exp_result = 0; exp_to = 0; exp_ab = 0; exp_cnt = 0;
      check_idle("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("after_mid_rst");
      gen_trace();
      do_run(1, 0, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
